// File: rtl/regfile_write_bank.sv
// Integer register file storage and write side: 32 x 64-bit registers, write decode,
// hardwired zero register, per-register busy scoreboard and a saturating write counter.
module regfile_write_bank #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [AW-1:0]                     wr_addr,
  input  logic [WIDTH-1:0]                  wr_data,
  input  logic                              busy_set,
  input  logic [AW-1:0]                     busy_addr,
  output logic [NUM_REGS-1:0][WIDTH-1:0]    regs,
  output logic [NUM_REGS-1:0]               busy,
  output logic [15:0]                       wr_count
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic        count_inc_s;
  logic [15:0] wr_count_d;
  logic [15:0] wr_count_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      // Constant zero: no storage, never busy.
      assign regs[i] = {WIDTH{1'b0}};
      assign busy[i] = 1'b0;
    end else begin : g_flop
      logic             wr_sel_s;
      logic             set_s;
      logic             clr_s;
      logic [WIDTH-1:0] data_d;
      logic [WIDTH-1:0] data_q;
      logic             busy_d;
      logic             busy_q;

      assign wr_sel_s = wr_en && (wr_addr == AW'(i));
      assign set_s    = busy_set && (busy_addr == AW'(i));
      assign clr_s    = wr_sel_s;

      // Next-state for data and scoreboard bit; a new producer outranks the retiring one.
      always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        if (wr_sel_s) begin
          data_d = wr_data;
        end else begin
          data_d = data_q;
        end
        if (set_s) begin
          busy_d = 1'b1;
        end else if (clr_s) begin
          busy_d = 1'b0;
        end else begin
          busy_d = busy_q;
        end
      end

      // Register and busy flop with asynchronous clear.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_q <= {WIDTH{1'b0}};
          busy_q <= 1'b0;
        end else begin
          data_q <= data_d;
          busy_q <= busy_d;
        end
      end

      assign regs[i] = data_q;
      assign busy[i] = busy_q;
    end
  end

  assign count_inc_s = wr_en && (wr_addr != ZERO_ADDR) && (wr_count_q != 16'hFFFF);

  // Saturating count of accepted (non-zero-register) writes.
  always_comb begin
    wr_count_d = wr_count_q;
    if (count_inc_s) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count_q <= 16'd0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_write_bank.sv
// Randomized and directed bench for regfile_write_bank against an array-based reference model.
module tb_regfile_write_bank;

  logic                clk;
  logic                reset;
  logic                wr_en;
  logic [4:0]          wr_addr;
  logic [63:0]         wr_data;
  logic                busy_set;
  logic [4:0]          busy_addr;
  logic [31:0][63:0]   regs;
  logic [31:0]         busy;
  logic [15:0]         wr_count;

  regfile_write_bank dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .regs      (regs),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] m_regs [32];
  logic [31:0] m_busy;
  int          m_cnt;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_busy = 32'd0;
    m_cnt  = 0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_regs%0d", tag, i), regs[i], m_regs[i]);
    chk({tag, "_busy"}, {32'd0, busy}, {32'd0, m_busy});
    chk({tag, "_count"}, {48'd0, wr_count}, 64'(m_cnt));
  endtask

  // Apply one cycle of stimulus and advance the model by the behavioural rules.
  task automatic step(input logic en, input logic [4:0] addr, input logic [63:0] data,
                      input logic bs, input logic [4:0] ba);
    @(negedge clk);
    wr_en = en; wr_addr = addr; wr_data = data; busy_set = bs; busy_addr = ba;
    @(posedge clk);
    if (en && addr != 5'd31) begin
      m_regs[addr] = data;
      if (m_cnt < 65535) m_cnt++;
    end
    if (en) m_busy[addr] = 1'b0;
    if (bs && ba != 5'd31) m_busy[ba] = 1'b1;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    wr_en = 1'b0; busy_set = 1'b0;
    #1 reset = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic release_reset();
    #1 reset = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 64'd0;
    busy_set = 1'b0; busy_addr = 5'd0;
    model_clear();
    #12;
    check_all("rst");

    // Reset held across an edge with active inputs must keep state clear.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234; busy_set = 1'b1; busy_addr = 5'd4;
    @(posedge clk); #1;
    check_all("rst_hold");
    @(negedge clk);
    wr_en = 1'b0; busy_set = 1'b0;
    reset = 1'b1;

    step(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 1'b0, 5'd0);
    check_all("wr5");

    step(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31);
    check_all("wr31");

    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    chk("busy7_set", {63'd0, busy[7]}, 64'd1);
    idle();
    step(1'b1, 5'd7, 64'h10, 1'b0, 5'd0);
    chk("busy7_clr", {63'd0, busy[7]}, 64'd0);
    check_all("x7");

    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
    step(1'b1, 5'd9, 64'h22, 1'b1, 5'd9);
    chk("busy9_setwins", {63'd0, busy[9]}, 64'd1);
    check_all("x9");

    pulse_reset();
    check_all("mid_rst");
    release_reset();
    for (int i = 0; i < 31; i++)
      step(1'b1, 5'(i), 64'(i) * 64'h0101_0101_0101_0101, 1'b1, 5'((i + 3) % 32));
    idle();
    check_all("fill31");
    chk("fill31_cnt", {48'd0, wr_count}, 64'd31);
    pulse_reset();
    check_all("async_rst");
    release_reset();

    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           {$urandom, $urandom}, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      check_all("rand");
    end

    pulse_reset();
    release_reset();
    for (int n = 0; n < 65534; n++)
      step(1'b1, 5'($urandom_range(0, 30)), {$urandom, $urandom}, 1'b0, 5'd0);
    chk("sat_fffe", {48'd0, wr_count}, 64'hFFFE);
    for (int n = 0; n < 3; n++)
      step(1'b1, 5'($urandom_range(0, 30)), {$urandom, $urandom}, 1'b0, 5'd0);
    chk("sat_ffff", {48'd0, wr_count}, 64'hFFFF);
    check_all("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
